dmem_io_arbiter: RTL and testbench

- Sits between the MEM stage and the data-side resources: data memory and the memory-mapped IO bus.
- Shares this port between two requesters: the CPU MEM stage and the debug unit (DBG).
- Sequences multi-cycle IO handshakes and generates the pipeline stall.
- Delivers read data to the MEM/WB register with the same address-bit IO decode used there.

---
 rtl/dmem_io_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_io_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_arbiter.sv
// dmem_io_arbiter
//   Shares the data-side port between the CPU MEM stage and the debug unit.
//   Data-memory accesses complete in one cycle. IO accesses run a registered
//   request/acknowledge handshake with a timeout. The block also produces the
//   pipeline stall.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        MEM stage access; cpu_rdata load data, cpu_stall freeze
//   dbg_req/we/addr/wdata        debug access (held until dbg_ack)
//   dbg_rdata, dbg_ack           registered debug read data, one-cycle completion pulse
//   mem_addr/we/wdata, mem_rdata data memory (read data combinational on mem_addr)
//   io_req/we/addr/wdata         registered IO request, held until io_ack or abort
//   io_ack, io_rdata             IO completion and read data
//   io_timeout                   sticky flag: an IO access was aborted
module dmem_io_arbiter #(
    parameter int unsigned IO_BIT  = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic        io_ack,
    input  logic [31:0] io_rdata,
    output logic        io_timeout
);

    typedef enum logic [1:0] {IDLE, IO_WAIT, IO_DONE} state_t;
    typedef enum logic {REQ_CPU, REQ_DBG} req_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    req_t        last_grant_q, last_grant_d;
    req_t        owner_q, owner_d;
    logic        io_req_q, io_req_d;
    logic        io_we_q, io_we_d;
    logic [31:0] io_addr_q, io_addr_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        io_timeout_q, io_timeout_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        cpu_act, dbg_act;
    req_t        winner;
    logic [31:0] win_addr, win_wdata;
    logic        win_we;

    // Request qualification and round-robin winner selection.
    // A debug request is masked while its ack is visible, because the debug
    // unit still holds dbg_req during the ack cycle.
    always_comb begin
        cpu_act = cpu_req & ~rst;
        dbg_act = dbg_req & ~dbg_ack_q & ~rst;
        if (cpu_act && dbg_act) begin
            winner = (last_grant_q == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (dbg_act) begin
            winner = REQ_DBG;
        end else begin
            winner = REQ_CPU;
        end
        win_addr  = (winner == REQ_DBG) ? dbg_addr  : cpu_addr;
        win_wdata = (winner == REQ_DBG) ? dbg_wdata : cpu_wdata;
        win_we    = (winner == REQ_DBG) ? dbg_we    : cpu_we;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        io_req_d     = io_req_q;
        io_we_d      = io_we_q;
        io_addr_d    = io_addr_q;
        io_wdata_d   = io_wdata_q;
        dbg_ack_d    = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        io_timeout_d = io_timeout_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        cpu_stall    = 1'b0;
        cpu_rdata    = '0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (cpu_act || dbg_act) begin
                    last_grant_d = winner;
                    if (!win_addr[IO_BIT]) begin
                        mem_addr  = win_addr;
                        mem_we    = win_we;
                        mem_wdata = win_wdata;
                        if (winner == REQ_CPU) begin
                            cpu_rdata = mem_rdata;
                        end else begin
                            dbg_rdata_d = mem_rdata;
                            dbg_ack_d   = 1'b1;
                            cpu_stall   = cpu_act;
                        end
                    end else begin
                        io_req_d   = 1'b1;
                        io_we_d    = win_we;
                        io_addr_d  = win_addr;
                        io_wdata_d = win_wdata;
                        owner_d    = winner;
                        cnt_d      = '0;
                        state_d    = IO_WAIT;
                        cpu_stall  = cpu_act;
                    end
                end
            end
            IO_WAIT: begin
                cpu_stall = cpu_act;
                cnt_d     = cnt_q + 8'd1;
                // An ack in the final allowed cycle wins over the timeout.
                if (io_ack) begin
                    rdata_d  = io_rdata;
                    io_req_d = 1'b0;
                    state_d  = IO_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rdata_d      = '0;
                    io_req_d     = 1'b0;
                    io_timeout_d = 1'b1;
                    state_d      = IO_DONE;
                end
            end
            IO_DONE: begin
                state_d = IDLE;
                if (owner_q == REQ_CPU) begin
                    cpu_rdata = rdata_q;
                end else begin
                    dbg_rdata_d = rdata_q;
                    dbg_ack_d   = 1'b1;
                    cpu_stall   = cpu_act;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            cpu_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_CPU;
            owner_q      <= REQ_CPU;
            io_req_q     <= 1'b0;
            io_we_q      <= 1'b0;
            io_addr_q    <= '0;
            io_wdata_q   <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= '0;
            io_timeout_q <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            io_req_q     <= io_req_d;
            io_we_q      <= io_we_d;
            io_addr_q    <= io_addr_d;
            io_wdata_q   <= io_wdata_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_rdata_q  <= dbg_rdata_d;
            io_timeout_q <= io_timeout_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    assign io_req     = io_req_q;
    assign io_we      = io_we_q;
    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;
    assign dbg_ack    = dbg_ack_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign io_timeout = io_timeout_q;

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// tb_dmem_io_arbiter
//   Directed scenarios followed by a randomized run. Expected behaviour comes
//   from a transaction-level reference model kept in this file. Inputs change
//   1 time unit after the rising edge; outputs are compared at the falling edge.
module tb_dmem_io_arbiter;
    localparam int unsigned IO_BIT  = 10;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        io_req, io_we, io_ack, io_timeout;
    logic [31:0] io_addr, io_wdata, io_rdata;

    logic        mem_fixed_en;
    logic [31:0] mem_fixed, salt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_busy;          // IO access outstanding
    bit          m_deliver;       // this cycle hands the IO result over
    bit          m_deliver_dbg;   // IO result belongs to the debug unit
    bit          m_dbg_turn;      // debug wins the next conflict
    int          m_io_cycles;     // cycles io_req has been high so far
    logic [31:0] m_deliver_val;
    logic        e_io_req, e_io_we, e_dbg_ack, e_timeout;
    logic [31:0] e_io_addr, e_io_wdata, e_dbg_rdata;

    logic        prev_x_stall, obs_stall, obs_ioreq, obs_ack;
    logic [31:0] obs_rdata;

    function automatic logic [31:0] mem_value(input logic [31:0] addr, input logic fixed_en,
                                              input logic [31:0] fixed, input logic [31:0] s);
        return fixed_en ? fixed : ({addr[15:0], addr[31:16]} ^ s ^ 32'h5A5A_0F0F);
    endfunction

    assign mem_rdata = mem_value(mem_addr, mem_fixed_en, mem_fixed, salt);

    always #5 clk = ~clk;

    dmem_io_arbiter #(.IO_BIT(IO_BIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata), .io_timeout(io_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_deliver = 0; m_deliver_dbg = 0; m_dbg_turn = 1; m_io_cycles = 0;
        m_deliver_val = '0;
        e_io_req = 0; e_io_we = 0; e_io_addr = '0; e_io_wdata = '0;
        e_dbg_ack = 0; e_dbg_rdata = '0; e_timeout = 0;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        io_ack = 0;
    endtask

    // One clock cycle: predict and compare outputs, then advance the model.
    task automatic step();
        bit          c_live, d_live, grant_mem, grant_io, we, x_stall, x_mwe, ack_s, rst_s;
        int          who;
        logic [31:0] a, wd, x_rdata, mval, rdata_s;
        @(negedge clk);
        rst_s   = rst;
        ack_s   = io_ack;
        rdata_s = io_rdata;
        c_live  = cpu_req && !rst_s;
        d_live  = dbg_req && !e_dbg_ack && !rst_s;
        who     = 0;
        if (!m_busy && !m_deliver && (c_live || d_live)) begin
            if (c_live && d_live) who = m_dbg_turn ? 2 : 1;
            else                  who = c_live ? 1 : 2;
        end
        a  = (who == 2) ? dbg_addr  : cpu_addr;
        wd = (who == 2) ? dbg_wdata : cpu_wdata;
        we = (who == 2) ? dbg_we    : cpu_we;
        grant_mem = (who != 0) && !a[IO_BIT];
        grant_io  = (who != 0) &&  a[IO_BIT];
        mval      = mem_value(a, mem_fixed_en, mem_fixed, salt);
        x_stall = 0; x_rdata = '0; x_mwe = 0;
        if (grant_mem) begin
            x_mwe = we;
            if (who == 1) x_rdata = mval;
            else          x_stall = c_live;
        end
        if (!rst_s) begin
            if (grant_io || m_busy) x_stall = c_live;
            if (m_deliver) begin
                if (m_deliver_dbg) x_stall = c_live;
                else               x_rdata = m_deliver_val;
            end
        end

        check("cpu_stall", {31'b0, cpu_stall}, {31'b0, x_stall});
        check("cpu_rdata", cpu_rdata, x_rdata);
        check("mem_we", {31'b0, mem_we}, {31'b0, x_mwe});
        if (grant_mem) begin
            check("mem_addr", mem_addr, a);
            check("mem_wdata", mem_wdata, wd);
        end
        check("io_req", {31'b0, io_req}, {31'b0, e_io_req});
        check("io_we", {31'b0, io_we}, {31'b0, e_io_we});
        check("io_addr", io_addr, e_io_addr);
        check("io_wdata", io_wdata, e_io_wdata);
        check("dbg_ack", {31'b0, dbg_ack}, {31'b0, e_dbg_ack});
        check("dbg_rdata", dbg_rdata, e_dbg_rdata);
        check("io_timeout", {31'b0, io_timeout}, {31'b0, e_timeout});

        prev_x_stall = x_stall;
        obs_stall    = cpu_stall;
        obs_ioreq    = io_req;
        obs_ack      = dbg_ack;
        obs_rdata    = cpu_rdata;

        @(posedge clk);
        if (rst_s) begin
            model_reset();
        end else begin
            e_dbg_ack = 0;
            if (m_deliver) begin
                m_deliver = 0;
                if (m_deliver_dbg) begin
                    e_dbg_ack   = 1;
                    e_dbg_rdata = m_deliver_val;
                end
            end else if (m_busy) begin
                m_io_cycles++;
                if (ack_s || m_io_cycles == int'(TIMEOUT)) begin
                    m_deliver_val = ack_s ? rdata_s : '0;
                    if (!ack_s) e_timeout = 1;
                    m_busy    = 0;
                    m_deliver = 1;
                    e_io_req  = 0;
                end
            end
            if (who != 0) begin
                m_dbg_turn = (who == 1);
                if (grant_mem) begin
                    if (who == 2) begin
                        e_dbg_ack   = 1;
                        e_dbg_rdata = mval;
                    end
                end else begin
                    m_busy        = 1;
                    m_io_cycles   = 0;
                    m_deliver_dbg = (who == 2);
                    e_io_req      = 1;
                    e_io_we       = we;
                    e_io_addr     = a;
                    e_io_wdata    = wd;
                end
            end
        end
        #1;
    endtask

    initial begin
        int cnt_stall, cnt_ioreq, cnt_ack, io_lat;
        bit dbg_release;
        model_reset();
        idle_inputs();
        mem_fixed_en = 0; mem_fixed = '0; salt = 32'h1357_9BDF; io_rdata = '0;
        prev_x_stall = 0;
        rst = 1;
        @(posedge clk); #1;
        step();
        cpu_req = 1; cpu_addr = 32'h0000_0440;
        step();                                    // request under reset is not granted
        check("rst_stall", {31'b0, obs_stall}, 32'd0);
        rst = 0; idle_inputs();
        step();

        // CPU memory load
        mem_fixed_en = 1; mem_fixed = 32'h1234_5678;
        cpu_req = 1; cpu_addr = 32'h0000_0040;
        step();
        check("t1_rdata", obs_rdata, 32'h1234_5678);
        check("t1_stall", {31'b0, obs_stall}, 32'd0);
        mem_fixed_en = 0; idle_inputs();
        step();
        check("t1_noio", {31'b0, obs_ioreq}, 32'd0);

        // CPU IO load, ack on the third io_req cycle
        cpu_req = 1; cpu_addr = 32'h0000_0400; io_rdata = 32'h0000_00A5;
        cnt_stall = 0; cnt_ioreq = 0;
        for (int i = 0; i < 5; i++) begin
            io_ack = e_io_req && (m_io_cycles == 2);
            step();
            cnt_stall += int'(obs_stall);
            cnt_ioreq += int'(obs_ioreq);
        end
        check("t2_rdata", obs_rdata, 32'h0000_00A5);
        check("t2_stall_cycles", cnt_stall, 4);
        check("t2_ioreq_cycles", cnt_ioreq, 3);
        idle_inputs();
        step();

        // Simultaneous memory requests after a CPU grant: debug first
        cpu_req = 1; cpu_addr = 32'h0000_0080;
        dbg_req = 1; dbg_addr = 32'h0000_0100;
        step();
        check("t3_stall", {31'b0, obs_stall}, 32'd1);
        cnt_ack = 0;
        step();
        cnt_ack += int'(obs_ack);
        check("t3_cpu_served", {31'b0, obs_stall}, 32'd0);
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            step();
            cnt_ack += int'(obs_ack);
        end
        check("t3_ack_pulses", cnt_ack, 1);

        // CPU IO store that never gets acked
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0404; cpu_wdata = 32'hDEAD_BEEF;
        cnt_ioreq = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            cnt_ioreq += int'(obs_ioreq);
        end
        check("t4_ioreq_cycles", cnt_ioreq, int'(TIMEOUT));
        check("t4_released", {31'b0, obs_stall}, 32'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        check("t4_sticky", {31'b0, io_timeout}, 32'd1);

        // Reset while a debug IO read is waiting
        dbg_req = 1; dbg_addr = 32'h0000_0408;
        for (int i = 0; i < 3; i++) step();
        rst = 1; dbg_req = 0;
        step();
        rst = 0; io_ack = 1; io_rdata = 32'h7777_7777;
        cnt_ack = 0;
        step();
        cnt_ack += int'(obs_ack);
        check("t5_ioreq", {31'b0, obs_ioreq}, 32'd0);
        io_ack = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            cnt_ack += int'(obs_ack);
        end
        check("t5_no_ack", cnt_ack, 0);
        check("t5_timeout_clr", {31'b0, io_timeout}, 32'd0);

        // Ack in the same cycle the timeout would fire
        cpu_req = 1; cpu_addr = 32'h0000_040C; io_rdata = 32'hC0FF_EE01;
        for (int i = 0; i < 18; i++) begin
            io_ack = e_io_req && (m_io_cycles == int'(TIMEOUT) - 1);
            step();
        end
        check("t6_rdata", obs_rdata, 32'hC0FF_EE01);
        check("t6_no_timeout", {31'b0, io_timeout}, 32'd0);
        idle_inputs();
        step();

        // Randomized traffic
        io_lat = 1; dbg_release = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst      = ($urandom_range(0, 299) == 0);
            salt     = $urandom;
            io_rdata = $urandom;
            if (!(prev_x_stall && cpu_req)) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom;
                cpu_addr[IO_BIT] = ($urandom_range(0, 3) == 0);
                cpu_wdata = $urandom;
            end
            if (dbg_req && e_dbg_ack) begin
                dbg_release = 1;
            end else if (dbg_release || !dbg_req) begin
                dbg_release = 0;
                dbg_req   = ($urandom_range(0, 3) == 0);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = $urandom;
                dbg_addr[IO_BIT] = ($urandom_range(0, 2) == 0);
                dbg_wdata = $urandom;
            end
            if (e_io_req) begin
                if (m_io_cycles == 0) io_lat = $urandom_range(1, TIMEOUT + 4);
                io_ack = (m_io_cycles + 1 == io_lat);
            end else begin
                io_ack = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
